// File: rtl/control32.sv
// rtl/control32.sv - Minisys-2.0 main control decoder with registered outputs
// Decodes opcode/function plus the load/store address page into datapath strobes.
module control32 #(
   parameter logic [21:0] IO_PAGE = 22'h3FFFFF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [5:0]  Opcode,
   input  logic [5:0]  Function_opcode,
   input  logic [21:0] Alu_resultHigh,
   output logic        Jrn,
   output logic        RegDST,
   output logic        ALUSrc,
   output logic        MemorIOtoReg,
   output logic        RegWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IORead,
   output logic        IOWrite,
   output logic        Branch,
   output logic        nBranch,
   output logic        Jmp,
   output logic        Jal,
   output logic        I_format,
   output logic        Sftmd,
   output logic [1:0]  ALUOp
);

   logic r_type, lw, sw, io_hit;
   logic d_jrn, d_regdst, d_alusrc, d_memortoreg, d_regwrite;
   logic d_memread, d_memwrite, d_ioread, d_iowrite;
   logic d_branch, d_nbranch, d_jmp, d_jal, d_iformat, d_sftmd;
   logic [1:0] d_aluop;

   always_comb begin
      r_type       = (Opcode == 6'b000000);
      lw           = (Opcode == 6'b100011);
      sw           = (Opcode == 6'b101011);
      io_hit       = (Alu_resultHigh == IO_PAGE);
      d_jrn        = r_type && (Function_opcode == 6'b001000);
      d_regdst     = r_type;
      d_iformat    = (Opcode[5:3] == 3'b001);
      d_alusrc     = d_iformat | lw | sw;
      d_jmp        = (Opcode == 6'b000010);
      d_jal        = (Opcode == 6'b000011);
      d_branch     = (Opcode == 6'b000100);
      d_nbranch    = (Opcode == 6'b000101);
      d_regwrite   = (r_type | lw | d_jal | d_iformat) & ~d_jrn;
      // The address page steers a load/store to exactly one of memory or I/O.
      d_memread    = lw & ~io_hit;
      d_ioread     = lw & io_hit;
      d_memwrite   = sw & ~io_hit;
      d_iowrite    = sw & io_hit;
      d_memortoreg = d_memread | d_ioread;
      d_sftmd      = r_type && (Function_opcode[5:3] == 3'b000);
      d_aluop      = {r_type | d_iformat, d_branch | d_nbranch};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         Jrn          <= 1'b0;
         RegDST       <= 1'b0;
         ALUSrc       <= 1'b0;
         MemorIOtoReg <= 1'b0;
         RegWrite     <= 1'b0;
         MemRead      <= 1'b0;
         MemWrite     <= 1'b0;
         IORead       <= 1'b0;
         IOWrite      <= 1'b0;
         Branch       <= 1'b0;
         nBranch      <= 1'b0;
         Jmp          <= 1'b0;
         Jal          <= 1'b0;
         I_format     <= 1'b0;
         Sftmd        <= 1'b0;
         ALUOp        <= 2'b00;
      end else begin
         Jrn          <= d_jrn;
         RegDST       <= d_regdst;
         ALUSrc       <= d_alusrc;
         MemorIOtoReg <= d_memortoreg;
         RegWrite     <= d_regwrite;
         MemRead      <= d_memread;
         MemWrite     <= d_memwrite;
         IORead       <= d_ioread;
         IOWrite      <= d_iowrite;
         Branch       <= d_branch;
         nBranch      <= d_nbranch;
         Jmp          <= d_jmp;
         Jal          <= d_jal;
         I_format     <= d_iformat;
         Sftmd        <= d_sftmd;
         ALUOp        <= d_aluop;
      end
   end

endmodule

// File: tb/tb_control32.sv
// tb/tb_control32.sv - directed bench for control32
// Outputs are packed as {Jrn,RegDST,ALUSrc,MemorIOtoReg,RegWrite}{MemRead,MemWrite,IORead,IOWrite}{Branch,nBranch,Jmp,Jal}{I_format,Sftmd}{ALUOp}.
module tb_control32;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [5:0]  Opcode = 6'd0;
   logic [5:0]  Function_opcode = 6'd0;
   logic [21:0] Alu_resultHigh = 22'd0;
   logic Jrn, RegDST, ALUSrc, MemorIOtoReg, RegWrite, MemRead, MemWrite;
   logic IORead, IOWrite, Branch, nBranch, Jmp, Jal, I_format, Sftmd;
   logic [1:0] ALUOp;
   logic [16:0] outv;

   int n_checks = 0;
   int n_fail = 0;

   localparam logic [21:0] MEM_ADDR = 22'h303483;
   localparam logic [21:0] IO_ADDR  = 22'h3FFFFF;

   always #5 clock = ~clock;

   control32 dut (
      .clock(clock), .reset_n(reset_n), .Opcode(Opcode),
      .Function_opcode(Function_opcode), .Alu_resultHigh(Alu_resultHigh),
      .Jrn(Jrn), .RegDST(RegDST), .ALUSrc(ALUSrc), .MemorIOtoReg(MemorIOtoReg),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .IORead(IORead), .IOWrite(IOWrite), .Branch(Branch), .nBranch(nBranch),
      .Jmp(Jmp), .Jal(Jal), .I_format(I_format), .Sftmd(Sftmd), .ALUOp(ALUOp)
   );

   assign outv = {Jrn, RegDST, ALUSrc, MemorIOtoReg, RegWrite,
                  MemRead, MemWrite, IORead, IOWrite,
                  Branch, nBranch, Jmp, Jal, I_format, Sftmd, ALUOp};

   task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [21:0] addr);
      @(negedge clock);
      Opcode = op;
      Function_opcode = fn;
      Alu_resultHigh = addr;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      Opcode = 6'b000000;
      Function_opcode = 6'b100000;
      repeat (2) @(posedge clock);
      #1;
      n_checks++;
      if (outv !== 17'b0) begin
         n_fail++;
         $display("FAIL reset_hold: got %b expected %b", outv, 17'b0);
      end
      @(negedge clock);
      reset_n = 1'b1;
      apply(6'b000000, 6'b100000, 22'd0);
      n_checks++;
      if (outv !== 17'b01001_0000_0000_00_10) begin
         n_fail++;
         $display("FAIL reset_release_add: got %b expected %b", outv, 17'b01001_0000_0000_00_10);
      end
   endtask

   task automatic test_rtype;
      apply(6'b000000, 6'b001000, 22'd0);
      n_checks++;
      if (outv !== 17'b11000_0000_0000_00_10) begin
         n_fail++;
         $display("FAIL jr: got %b expected %b", outv, 17'b11000_0000_0000_00_10);
      end
      apply(6'b000000, 6'b000010, IO_ADDR);
      n_checks++;
      if (outv !== 17'b01001_0000_0000_01_10) begin
         n_fail++;
         $display("FAIL srl: got %b expected %b", outv, 17'b01001_0000_0000_01_10);
      end
   endtask

   task automatic test_iformat;
      apply(6'b001000, 6'b000000, 22'd0);
      n_checks++;
      if (outv !== 17'b00101_0000_0000_10_10) begin
         n_fail++;
         $display("FAIL addi: got %b expected %b", outv, 17'b00101_0000_0000_10_10);
      end
      apply(6'b001101, 6'b111111, IO_ADDR);
      n_checks++;
      if (outv !== 17'b00101_0000_0000_10_10) begin
         n_fail++;
         $display("FAIL ori_io_page: got %b expected %b", outv, 17'b00101_0000_0000_10_10);
      end
   endtask

   task automatic test_load_store;
      apply(6'b100011, 6'b000000, MEM_ADDR);
      n_checks++;
      if (outv !== 17'b00111_1000_0000_00_00) begin
         n_fail++;
         $display("FAIL lw_mem: got %b expected %b", outv, 17'b00111_1000_0000_00_00);
      end
      apply(6'b100011, 6'b000000, IO_ADDR);
      n_checks++;
      if (outv !== 17'b00111_0010_0000_00_00) begin
         n_fail++;
         $display("FAIL lw_io: got %b expected %b", outv, 17'b00111_0010_0000_00_00);
      end
      apply(6'b101011, 6'b000000, MEM_ADDR);
      n_checks++;
      if (outv !== 17'b00100_0100_0000_00_00) begin
         n_fail++;
         $display("FAIL sw_mem: got %b expected %b", outv, 17'b00100_0100_0000_00_00);
      end
      apply(6'b101011, 6'b000000, IO_ADDR);
      n_checks++;
      if (outv !== 17'b00100_0001_0000_00_00) begin
         n_fail++;
         $display("FAIL sw_io: got %b expected %b", outv, 17'b00100_0001_0000_00_00);
      end
      apply(6'b100011, 6'b000000, 22'h3FFFFE);
      n_checks++;
      if (outv !== 17'b00111_1000_0000_00_00) begin
         n_fail++;
         $display("FAIL lw_below_io_page: got %b expected %b", outv, 17'b00111_1000_0000_00_00);
      end
   endtask

   task automatic test_control_flow;
      apply(6'b000100, 6'b000000, 22'd0);
      n_checks++;
      if (outv !== 17'b00000_0000_1000_00_01) begin
         n_fail++;
         $display("FAIL beq: got %b expected %b", outv, 17'b00000_0000_1000_00_01);
      end
      apply(6'b000101, 6'b000000, 22'd0);
      n_checks++;
      if (outv !== 17'b00000_0000_0100_00_01) begin
         n_fail++;
         $display("FAIL bne: got %b expected %b", outv, 17'b00000_0000_0100_00_01);
      end
      apply(6'b000010, 6'b000000, 22'd0);
      n_checks++;
      if (outv !== 17'b00000_0000_0010_00_00) begin
         n_fail++;
         $display("FAIL j: got %b expected %b", outv, 17'b00000_0000_0010_00_00);
      end
      apply(6'b000011, 6'b000000, 22'd0);
      n_checks++;
      if (outv !== 17'b00001_0000_0001_00_00) begin
         n_fail++;
         $display("FAIL jal: got %b expected %b", outv, 17'b00001_0000_0001_00_00);
      end
   endtask

   task automatic test_unlisted;
      apply(6'b111111, 6'b100000, IO_ADDR);
      n_checks++;
      if (outv !== 17'b0) begin
         n_fail++;
         $display("FAIL unlisted_opcode: got %b expected %b", outv, 17'b0);
      end
   endtask

   task automatic test_between_edges;
      apply(6'b000000, 6'b100000, 22'd0);
      #1;
      Opcode = 6'b000100;
      #2;
      n_checks++;
      if (outv !== 17'b01001_0000_0000_00_10) begin
         n_fail++;
         $display("FAIL hold_between_edges: got %b expected %b", outv, 17'b01001_0000_0000_00_10);
      end
      @(posedge clock);
      #1;
      n_checks++;
      if (outv !== 17'b00000_0000_1000_00_01) begin
         n_fail++;
         $display("FAIL load_next_edge: got %b expected %b", outv, 17'b00000_0000_1000_00_01);
      end
   endtask

   task automatic test_async_reset;
      apply(6'b000011, 6'b000000, 22'd0);
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (outv !== 17'b0) begin
         n_fail++;
         $display("FAIL async_reset_immediate: got %b expected %b", outv, 17'b0);
      end
      @(posedge clock);
      #1;
      n_checks++;
      if (outv !== 17'b0) begin
         n_fail++;
         $display("FAIL reset_held_edge: got %b expected %b", outv, 17'b0);
      end
      @(negedge clock);
      reset_n = 1'b1;
      apply(6'b100011, 6'b000000, IO_ADDR);
      n_checks++;
      if (outv !== 17'b00111_0010_0000_00_00) begin
         n_fail++;
         $display("FAIL after_reset_lw_io: got %b expected %b", outv, 17'b00111_0010_0000_00_00);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_iformat();
      test_load_store();
      test_control_flow();
      test_unlisted();
      test_between_edges();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
